// File: rtl/button_events.sv
// Debounced button inputs with rise/fall event flags, W1C event register and level IRQ.
// Optional fall events and fall IRQ enables are built when BUTTON_EVENTS_FALL_EN is defined.
module button_events #(
   parameter int unsigned BUTTONCOUNT     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 36000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BUTTONCOUNT-1:0] buttons_in,
   input  logic [31:0]            address_in,
   input  logic                   sel_in,
   input  logic                   read_in,
   output logic [31:0]            read_value_out,
   input  logic [3:0]             write_mask_in,
   input  logic [31:0]            write_value_in,
   output logic                   ready_out,
   output logic                   irq_out
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]      BTN_MASK = 16'((32'd1 << BUTTONCOUNT) - 32'd1);
`ifdef BUTTON_EVENTS_FALL_EN
   localparam logic [31:0]      IMPL_MASK = {BTN_MASK, BTN_MASK};
`else
   localparam logic [31:0]      IMPL_MASK = {16'd0, BTN_MASK};
`endif

   localparam logic [1:0] ADDR_STATE  = 2'd0;
   localparam logic [1:0] ADDR_EVENTS = 2'd1;
   localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

   logic [BUTTONCOUNT-1:0] sync1;
   logic [BUTTONCOUNT-1:0] sync2;
   logic [BUTTONCOUNT-1:0] stable;
   logic [CNT_W-1:0]       cnt [BUTTONCOUNT];
   logic [BUTTONCOUNT-1:0] accept_c;

   logic [31:0] events;
   logic [31:0] irq_en;
   logic [31:0] byte_mask_c;
   logic [31:0] ev_set_c;
   logic [31:0] ev_clr_c;
   logic [31:0] events_next_c;
   logic [31:0] irq_en_next_c;
   logic [31:0] read_data_c;
   logic        wr_c;
   logic        unused_bus;

   // A changed input is accepted on the cycle its mismatch count reaches the last step
   always_comb begin
      accept_c = '0;
      for (int i = 0; i < BUTTONCOUNT; i++) begin
         accept_c[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
      end
   end

   // Synchronizers, debounce counters and debounced state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < BUTTONCOUNT; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= buttons_in;
         sync2 <= sync1;
         for (int i = 0; i < BUTTONCOUNT; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (accept_c[i]) begin
               cnt[i]    <= '0;
               stable[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Event set/clear and IRQ enable update; a set in the same cycle as a clear wins
   always_comb begin
      byte_mask_c = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                     {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
      wr_c        = sel_in && (write_mask_in != 4'd0);
      ev_set_c    = {16'(accept_c & ~sync2), 16'(accept_c & sync2)} & IMPL_MASK;
      ev_clr_c    = '0;
      irq_en_next_c = irq_en;
      if (wr_c && (address_in[3:2] == ADDR_EVENTS)) begin
         ev_clr_c = write_value_in & byte_mask_c;
      end
      if (wr_c && (address_in[3:2] == ADDR_IRQ_EN)) begin
         irq_en_next_c = ((irq_en & ~byte_mask_c) | (write_value_in & byte_mask_c)) & IMPL_MASK;
      end
      events_next_c = ((events & ~ev_clr_c) | ev_set_c) & IMPL_MASK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         events  <= '0;
         irq_en  <= '0;
         irq_out <= 1'b0;
      end else begin
         events  <= events_next_c;
         irq_en  <= irq_en_next_c;
         irq_out <= |(events & irq_en);
      end
   end

   // Zero-wait-state read mux; output is forced to zero when not selected
   always_comb begin
      read_data_c = '0;
      case (address_in[3:2])
         ADDR_STATE:  read_data_c = 32'(stable);
         ADDR_EVENTS: read_data_c = events;
         ADDR_IRQ_EN: read_data_c = irq_en;
         default:     read_data_c = '0;
      endcase
   end

   assign read_value_out = sel_in ? read_data_c : 32'd0;
   assign ready_out      = sel_in;

   // Bus bits that the register map does not decode
   assign unused_bus = ^{read_in, address_in[31:4], address_in[1:0]};

endmodule

// File: tb/tb_button_events.sv
// Scoreboarded random bench for button_events against a sample-history reference model.
module tb_button_events;

   localparam int unsigned BC = 4;
   localparam int unsigned DC = 4;
   localparam logic [31:0] RISE_MASK = 32'((1 << BC) - 1);
`ifdef BUTTON_EVENTS_FALL_EN
   localparam logic [31:0] IMPL = RISE_MASK | (RISE_MASK << 16);
`else
   localparam logic [31:0] IMPL = RISE_MASK;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [BC-1:0] buttons_in = '0;
   logic [31:0]   address_in = '0;
   logic          sel_in = 1'b0;
   logic          read_in = 1'b0;
   logic [31:0]   read_value_out;
   logic [3:0]    write_mask_in = '0;
   logic [31:0]   write_value_in = '0;
   logic          ready_out;
   logic          irq_out;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q [$];
   logic [31:0] addr_q [$];
   logic [BC-1:0] btn = '0;

   // Reference model state
   logic [BC-1:0] hist [$];
   logic [BC-1:0] m_state;
   logic [31:0]   m_events;
   logic [31:0]   m_irq_en;
   logic          m_irq;

   button_events #(.BUTTONCOUNT(BC), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .buttons_in(buttons_in), .address_in(address_in),
      .sel_in(sel_in), .read_in(read_in), .read_value_out(read_value_out),
      .write_mask_in(write_mask_in), .write_value_in(write_value_in),
      .ready_out(ready_out), .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lane_mask(input logic [3:0] wm);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (wm[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[3:2])
         2'd0:    return 32'(m_state);
         2'd1:    return m_events;
         2'd2:    return m_irq_en;
         default: return 32'd0;
      endcase
   endfunction

   // hist holds the last DC+2 pin samples; a level is accepted once the DC samples
   // that have reached the far end of the synchronizer all agree and differ from STATE.
   always @(posedge clk or negedge reset) begin : model
      logic [BC-1:0] nxt;
      logic [BC-1:0] ref_s;
      logic [BC-1:0] t;
      logic [31:0]   set_v;
      logic [31:0]   clr_v;
      logic [31:0]   bm;
      logic          run_ok;
      if (!reset) begin
         hist = {};
         for (int k = 0; k < int'(DC) + 2; k++) hist.push_back('0);
         m_state  = '0;
         m_events = '0;
         m_irq_en = '0;
         m_irq    = 1'b0;
      end else begin
         m_irq = |(m_events & m_irq_en);
         nxt   = m_state;
         set_v = '0;
         ref_s = hist[DC];
         for (int i = 0; i < int'(BC); i++) begin
            run_ok = 1'b1;
            for (int k = 1; k <= int'(DC); k++) begin
               t = hist[k];
               if (t[i] != ref_s[i]) run_ok = 1'b0;
            end
            if (run_ok && (ref_s[i] != m_state[i])) begin
               nxt[i] = ref_s[i];
               if (ref_s[i]) set_v[i] = 1'b1;
               else          set_v[16 + i] = 1'b1;
            end
         end
         set_v = set_v & IMPL;
         bm    = lane_mask(write_mask_in);
         clr_v = '0;
         if (sel_in && (write_mask_in != 4'd0)) begin
            if (address_in[3:2] == 2'd1) clr_v = write_value_in & bm;
            if (address_in[3:2] == 2'd2) m_irq_en = ((m_irq_en & ~bm) | (write_value_in & bm)) & IMPL;
         end
         m_events = (m_events & ~clr_v) | set_v;
         m_state  = nxt;
         hist.push_back(buttons_in);
         void'(hist.pop_front());
      end
   end

   // Monitor: compares every presented read plus the per-cycle handshake and IRQ level
   always @(negedge clk) begin
      logic [31:0] e;
      logic [31:0] a;
      if (reset) begin
         n_vec++;
         if (ready_out !== sel_in) begin
            n_err++;
            $display("FAIL ready_out got %b want %b", ready_out, sel_in);
         end
         n_vec++;
         if (irq_out !== m_irq) begin
            n_err++;
            $display("FAIL irq_out at %0t got %b want %b", $time, irq_out, m_irq);
         end
         if (!sel_in) begin
            n_vec++;
            if (read_value_out !== 32'd0) begin
               n_err++;
               $display("FAIL unselected_read got %h want 00000000", read_value_out);
            end
         end else if (read_in && ready_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL read_unexpected got %h want no read", read_value_out);
            end else begin
               e = exp_q.pop_front();
               a = addr_q.pop_front();
               if (read_value_out !== e) begin
                  n_err++;
                  $display("FAIL read reg%0d at %0t got %h want %h", a[3:2], $time, read_value_out, e);
               end
            end
         end
      end
   end

   task automatic cyc(input logic sel, input logic rd, input logic [31:0] a,
                      input logic [3:0] wm, input logic [31:0] wv);
      @(posedge clk);
      #1;
      buttons_in = btn; sel_in = sel; read_in = rd; address_in = a;
      write_mask_in = wm; write_value_in = wv;
      if (sel && rd) begin
         exp_q.push_back(model_read(a));
         addr_q.push_back(a);
      end
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1'b1, 1'b1, a, 4'd0, 32'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] v);
      cyc(1'b1, 1'b0, a, wm, v);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0;
      #2 reset = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
   endtask

   initial begin
      int hold;
      int r;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);

      // clean rise on bit 0, STATE polled every cycle across the latency window
      btn = 4'b0001;
      repeat (8) rd(32'h0);
      rd(32'h4);

      // 3-cycle glitch on bit 1 must be rejected
      btn = 4'b0011;
      idle(); idle(); idle();
      btn = 4'b0001;
      repeat (8) rd(32'h0);
      rd(32'h4);

      // enable bit-0 IRQ, then fall and rise again
      wr(32'h4, 4'hF, 32'hFFFF_FFFF);
      wr(32'h8, 4'hF, 32'h0000_0001);
      rd(32'h8);
      btn = 4'b0000;
      repeat (8) rd(32'h4);
      wr(32'h4, 4'hF, 32'hFFFF_FFFF);
      btn = 4'b0001;
      repeat (8) rd(32'h4);
      wr(32'h4, 4'h1, 32'h0000_0001);
      idle(); idle();

      // clear arrives on exactly the cycle a new rise is accepted
      btn = 4'b0000;
      repeat (8) idle();
      wr(32'h4, 4'hF, 32'hFFFF_FFFF);
      btn = 4'b0001;
      idle(); idle(); idle(); idle(); idle();
      wr(32'h4, 4'hF, 32'h0000_0001);
      rd(32'h4);

      // fall-enable bits write/read back
      wr(32'h8, 4'hF, 32'h0001_0000);
      rd(32'h8);
      wr(32'hC, 4'hF, 32'hFFFF_FFFF);
      rd(32'hC);

      // unselected bus with arbitrary addresses
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, $urandom, 4'($urandom), $urandom);

      // reset in the middle of a debounce count
      btn = 4'b0101;
      idle(); idle(); idle();
      pulse_reset();
      rd(32'h0); rd(32'h4); rd(32'h8);

      // randomized traffic
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            btn  = BC'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         r = $urandom_range(0, 99);
         if (r < 45)      rd($urandom);
         else if (r < 62) wr($urandom, 4'($urandom), $urandom);
         else if (r < 67) cyc(1'b0, 1'b0, $urandom, 4'($urandom), $urandom);
         else if (r < 70) pulse_reset();
         else             idle();
      end

      idle();
      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL read_drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
